// File: rtl/mode3_pkg.sv
// Shared types and widths for the sequenced mode-3 datapath (out = floor(sqrt(a^2+b^2))^3).
// Build option MODE3_SEQ_BACK2BACK_EN is consumed by mode3_seq_ctrl, not by this package.
package mode3_pkg;

    localparam int DEF_IN_W  = 3;
    localparam int DEF_OUT_W = 12;

    localparam int SUM_W  = 2 * DEF_IN_W + 1;   // a^2 + b^2, max 98
    localparam int ROOT_W = DEF_IN_W + 1;       // floor(sqrt), max 9
    localparam int SQ_W   = 2 * ROOT_W;         // root^2, max 81
    localparam int RAD_W  = SUM_W + 1;          // radicand padded to whole bit pairs
    localparam int REM_W  = ROOT_W + 2;
    localparam int CUBE_W = 10;                 // root^3, max 729

    localparam int MUL_A_W = 8;
    localparam int MUL_B_W = 4;
    localparam int MUL_P_W = MUL_A_W + MUL_B_W;

    localparam int LATENCY = 9;

    typedef enum logic [2:0] {
        IDLE,
        SQ_A,
        SQ_B,
        SQRT,
        CUBE1,
        CUBE2,
        DONE
    } state_t;

endpackage

// File: rtl/mode3_mul.sv
// Combinational 8x4 unsigned multiplier, shared by every arithmetic step of mode3_seq_ctrl.
module mode3_mul
    import mode3_pkg::*;
(
    input  logic [MUL_A_W-1:0] i_a,
    input  logic [MUL_B_W-1:0] i_b,
    output logic [MUL_P_W-1:0] o_p
);

    assign o_p = MUL_P_W'(i_a) * MUL_P_W'(i_b);

endmodule

// File: rtl/mode3_seq_ctrl.sv
// Sequenced mode-3 engine: a^2+b^2, restoring sqrt (one root bit per cycle), then cube.
// Define MODE3_SEQ_BACK2BACK_EN to accept a new start in the DONE cycle.
module mode3_seq_ctrl
    import mode3_pkg::*;
#(
    parameter int IN_W     = DEF_IN_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int SQRT_CYC = IN_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IN_W-1:0]  a_in,
    input  logic [IN_W-1:0]  b_in,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] out_8x
);

    localparam int CNT_W = (SQRT_CYC > 1) ? $clog2(SQRT_CYC) : 1;
    localparam logic [OUT_W-1:0] CUBE_MASK = OUT_W'((1 << CUBE_W) - 1);

    state_t             r_state;
    logic [IN_W-1:0]    r_a;
    logic [IN_W-1:0]    r_b;
    logic [SUM_W-1:0]   r_acc;
    logic [REM_W-1:0]   r_rem;
    logic [ROOT_W-1:0]  r_root;
    logic [SQ_W-1:0]    r_sq;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [OUT_W-1:0]   r_out;

    logic [MUL_A_W-1:0] w_mul_a;
    logic [MUL_B_W-1:0] w_mul_b;
    logic [MUL_P_W-1:0] w_prod;

    logic [RAD_W-1:0]   w_rad;
    logic [RAD_W-1:0]   w_rad_sh;
    logic [1:0]         w_next2;
    logic [RAD_W-1:0]   w_t;
    logic [RAD_W-1:0]   w_trial;
    logic [RAD_W-1:0]   w_diff;
    logic               w_ge;
    logic [REM_W-1:0]   w_rem_nxt;
    logic [ROOT_W-1:0]  w_root_nxt;

    assign busy   = r_busy;
    assign done   = r_done;
    assign out_8x = r_out;

    // Operand steering for the single shared multiplier; idle states feed zero.
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        case (r_state)
            SQ_A: begin
                w_mul_a = MUL_A_W'(r_a);
                w_mul_b = MUL_B_W'(r_a);
            end
            SQ_B: begin
                w_mul_a = MUL_A_W'(r_b);
                w_mul_b = MUL_B_W'(r_b);
            end
            CUBE1: begin
                w_mul_a = MUL_A_W'(r_root);
                w_mul_b = r_root;
            end
            CUBE2: begin
                w_mul_a = r_sq;
                w_mul_b = r_root;
            end
            default: begin
                w_mul_a = '0;
                w_mul_b = '0;
            end
        endcase
    end

    mode3_mul u_mul (
        .i_a (w_mul_a),
        .i_b (w_mul_b),
        .o_p (w_prod)
    );

    // Restoring square root: bring down the next bit pair MSB-first and try (root<<2)|1.
    assign w_rad      = RAD_W'(r_acc);
    assign w_rad_sh   = w_rad >> (2 * (SQRT_CYC - 1 - int'(r_cnt)));
    assign w_next2    = 2'(w_rad_sh);
    assign w_t        = RAD_W'({r_rem, w_next2});
    assign w_trial    = RAD_W'({r_root, 2'b01});
    assign w_ge       = (w_t >= w_trial);
    assign w_diff     = w_t - w_trial;
    assign w_rem_nxt  = w_ge ? REM_W'(w_diff) : REM_W'(w_t);
    assign w_root_nxt = {r_root[ROOT_W-2:0], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_rem   <= '0;
            r_root  <= '0;
            r_sq    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_out   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_acc   <= '0;
                        r_rem   <= '0;
                        r_root  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SQ_A;
                    end
                end
                SQ_A: begin
                    r_acc   <= SUM_W'(w_prod);
                    r_state <= SQ_B;
                end
                SQ_B: begin
                    r_acc   <= r_acc + SUM_W'(w_prod);
                    r_cnt   <= '0;
                    r_state <= SQRT;
                end
                SQRT: begin
                    r_rem  <= w_rem_nxt;
                    r_root <= w_root_nxt;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(SQRT_CYC - 1)) begin
                        r_state <= CUBE1;
                    end
                end
                CUBE1: begin
                    r_sq    <= SQ_W'(w_prod);
                    r_state <= CUBE2;
                end
                CUBE2: begin
                    r_out   <= w_prod & CUBE_MASK;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_done <= 1'b0;
`ifdef MODE3_SEQ_BACK2BACK_EN
                    if (start) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_acc   <= '0;
                        r_rem   <= '0;
                        r_root  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SQ_A;
                    end else begin
                        r_state <= IDLE;
                    end
`else
                    r_state <= IDLE;
`endif
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
